// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for a 4-bit combinational ALU.
// Owns an NREG x 4-bit register file, drives the ALU operands from registers,
// and writes the ALU result and flags back on each EXEC edge. An optional
// repeat count re-applies the same operation to the destination register.
//
// The ALU drive outputs are registered. For iterations after the first, the
// next operands are taken from the value being written on the same edge, so
// the ALU sees exactly the register contents the EXEC cycle would read.
module alu_cmd_sequencer #(
  parameter int unsigned NREG = 4,
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [3:0]    cmd_imm,
  input  logic [1:0]    cmd_rep,

  output logic [2:0]    alu_select,
  output logic          alu_in_c,
  output logic [3:0]    alu_in_x,
  output logic [3:0]    alu_in_y,
  input  logic [3:0]    alu_out_s,
  input  logic          alu_out_c,
  input  logic          alu_zero,
  input  logic          alu_overflow,

  output logic          done,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_v,

  input  logic [AW-1:0] dbg_addr,
  output logic [3:0]    dbg_data
);

  localparam int unsigned DW = 4;

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs2_q;
  logic             imm_en_q;
  logic [DW-1:0]    imm_q;
  logic [1:0]       cnt;
  logic [DW-1:0]    regs [NREG];

  logic [DW-1:0]    wdata;
  logic [DW-1:0]    y_next;
  logic             in_c_new;
  logic [DW-1:0]    y_new;

  // Ready is a decode of the state register, forced low while reset is held
  assign cmd_ready = rst_n & (state == IDLE);

  // Debug read port reflects the register file directly
  assign dbg_data = regs[dbg_addr];

  // Writeback value and next-iteration y operand (bypass when rs2 aliases rd)
  always_comb begin
    wdata = alu_out_s;
    if (op_q == OP_SLT || op_q == OP_EQ) begin
      wdata = {3'b000, alu_out_s[0]};
    end
    y_next = regs[rs2_q];
    if (imm_en_q) begin
      y_next = imm_q;
    end else if (rs2_q == rd_q) begin
      y_next = wdata;
    end
  end

  // Operand selection for a newly presented command
  always_comb begin
    in_c_new = (cmd_op == OP_SUB) || (cmd_op == OP_SLT) || (cmd_op == OP_EQ);
    y_new    = cmd_imm_en ? cmd_imm : regs[cmd_rs2];
  end

  // Sequencer FSM, register file, flags and registered ALU drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 3'b000;
      rd_q       <= '0;
      rs2_q      <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      cnt        <= 2'd0;
      done       <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      alu_select <= 3'b000;
      alu_in_c   <= 1'b0;
      alu_in_x   <= '0;
      alu_in_y   <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            rd_q       <= cmd_rd;
            rs2_q      <= cmd_rs2;
            imm_en_q   <= cmd_imm_en;
            imm_q      <= cmd_imm;
            cnt        <= cmd_rep;
            alu_select <= cmd_op;
            alu_in_c   <= in_c_new;
            alu_in_x   <= regs[cmd_rs1];
            alu_in_y   <= y_new;
            state      <= EXEC;
          end
        end
        EXEC: begin
          regs[rd_q] <= wdata;
          flag_c     <= alu_out_c;
          flag_z     <= alu_zero;
          flag_v     <= alu_overflow;
          if (cnt == 2'd0) begin
            state      <= IDLE;
            done       <= 1'b1;
            alu_select <= 3'b000;
            alu_in_c   <= 1'b0;
            alu_in_x   <= '0;
            alu_in_y   <= '0;
          end else begin
            cnt      <= cnt - 2'd1;
            alu_in_x <= wdata;
            alu_in_y <= y_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural 4-bit ALU
// connected to the ALU drive ports.
module tb_alu_cmd_sequencer;

  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic          cmd_imm_en;
  logic [3:0]    cmd_imm;
  logic [1:0]    cmd_rep;
  logic [2:0]    alu_select;
  logic          alu_in_c;
  logic [3:0]    alu_in_x;
  logic [3:0]    alu_in_y;
  logic [3:0]    alu_out_s;
  logic          alu_out_c;
  logic          alu_zero;
  logic          alu_overflow;
  logic          done;
  logic          flag_c;
  logic          flag_z;
  logic          flag_v;
  logic [AW-1:0] dbg_addr;
  logic [3:0]    dbg_data;

  int errors;
  int checks;

  alu_cmd_sequencer #(.NREG(NREG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm_en   (cmd_imm_en),
    .cmd_imm      (cmd_imm),
    .cmd_rep      (cmd_rep),
    .alu_select   (alu_select),
    .alu_in_c     (alu_in_c),
    .alu_in_x     (alu_in_x),
    .alu_in_y     (alu_in_y),
    .alu_out_s    (alu_out_s),
    .alu_out_c    (alu_out_c),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .done         (done),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: in_c inverts y and supplies the carry-in
  logic [3:0] yy;
  logic [4:0] sum;
  logic       ov;
  logic       lt;
  logic [3:0] s;
  always_comb begin
    yy  = alu_in_c ? ~alu_in_y : alu_in_y;
    sum = 5'(alu_in_x) + 5'(yy) + 5'(alu_in_c);
    ov  = (alu_in_x[3] == yy[3]) && (sum[3] != alu_in_x[3]);
    lt  = sum[3] ^ ov;
    case (alu_select)
      3'b000, 3'b001: s = sum[3:0];
      3'b010:         s = ~alu_in_x;
      3'b011:         s = alu_in_x & alu_in_y;
      3'b100:         s = alu_in_x | alu_in_y;
      3'b101:         s = alu_in_x ^ alu_in_y;
      3'b110:         s = {3'b000, lt};
      default:        s = {3'b000, (sum[3:0] == 4'h0)};
    endcase
    alu_out_s    = s;
    alu_out_c    = sum[4];
    alu_overflow = ov;
    alu_zero     = (s == 4'h0);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [AW-1:0] a, input string tag, input logic [3:0] exp);
    dbg_addr = a;
    #1;
    check(tag, 8'(dbg_data), 8'(exp));
  endtask

  task automatic present(input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic imm_en, input logic [3:0] imm, input logic [1:0] rep);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm_en = imm_en;
    cmd_imm    = imm;
    cmd_rep    = rep;
  endtask

  // Load an immediate into a register via 0 + imm (R0 stays zero in this bench)
  task automatic load(input logic [AW-1:0] rd, input logic [3:0] val);
    present(3'b000, rd, 2'd0, 2'd0, 1'b1, val, 2'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("load_done", 8'(done), 8'h1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    dbg_addr = '0;
    present(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 2'd0);
    cmd_valid = 1'b0;

    // Reset
    tick();
    tick();
    check("ready_in_reset", 8'(cmd_ready), 8'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 8'(cmd_ready), 8'h1);
    for (int a = 0; a < int'(NREG); a++) begin
      peek(AW'(a), "reset_reg", 4'h0);
    end
    check("reset_flags", 8'({flag_c, flag_z, flag_v}), 8'h0);
    check("reset_done", 8'(done), 8'h0);
    tick();
    check("ready_idle", 8'(cmd_ready), 8'h1);

    // Immediate add: R1 = R0 + 5
    present(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'h5, 2'd0);
    tick();
    cmd_valid = 1'b0;
    check("add_in_c", 8'(alu_in_c), 8'h0);
    check("add_in_x", 8'(alu_in_x), 8'h0);
    check("add_in_y", 8'(alu_in_y), 8'h5);
    check("add_ready_exec", 8'(cmd_ready), 8'h0);
    tick();
    check("add_done", 8'(done), 8'h1);
    check("add_flag_z", 8'(flag_z), 8'h0);
    check("add_ready_back", 8'(cmd_ready), 8'h1);
    check("add_idle_sel", 8'({alu_select, alu_in_c, alu_in_x}), 8'h0);
    peek(2'd1, "add_r1", 4'h5);
    tick();
    check("done_pulse_drop", 8'(done), 8'h0);

    // Subtract: R3 = R1 - R2 = 5 - 7
    load(2'd2, 4'h7);
    present(3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 2'd0);
    tick();
    cmd_valid = 1'b0;
    check("sub_in_c", 8'(alu_in_c), 8'h1);
    check("sub_in_x", 8'(alu_in_x), 8'h5);
    check("sub_in_y", 8'(alu_in_y), 8'h7);
    tick();
    peek(2'd3, "sub_r3", 4'hE);
    check("sub_flag_v", 8'(flag_v), 8'h0);
    check("sub_flag_c", 8'(flag_c), 8'h0);

    // Repeat add on R1 with cmd_valid held high throughout
    load(2'd1, 4'h3);
    present(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 4'h3, 2'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rep_x", 8'(alu_in_x), 8'(3 * (k + 1)));
      check("rep_ready_low", 8'(cmd_ready), 8'h0);
      check("rep_no_done", 8'(done), 8'h0);
    end
    tick();
    check("rep_done", 8'(done), 8'h1);
    check("rep_ready", 8'(cmd_ready), 8'h1);
    peek(2'd1, "rep_r1", 4'hF);
    // Held command is accepted in the done cycle
    tick();
    cmd_valid = 1'b0;
    check("b2b_accept_x", 8'(alu_in_x), 8'hF);
    check("b2b_ready", 8'(cmd_ready), 8'h0);
    for (int k = 0; k < 3; k++) tick();
    check("b2b_last_x", 8'(alu_in_x), 8'h8);
    tick();
    check("b2b_done", 8'(done), 8'h1);
    peek(2'd1, "b2b_r1", 4'hB);

    // Signed less-than and equality
    load(2'd1, 4'hF);
    load(2'd2, 4'h1);
    present(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 2'd0);
    tick();
    cmd_valid = 1'b0;
    check("slt_in_c", 8'(alu_in_c), 8'h1);
    tick();
    peek(2'd3, "slt_r3", 4'h1);
    present(3'b111, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 2'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    peek(2'd3, "eq_ne_r3", 4'h0);
    check("eq_ne_flag_z", 8'(flag_z), 8'h1);
    present(3'b111, 2'd3, 2'd2, 2'd2, 1'b0, 4'h0, 2'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    peek(2'd3, "eq_r3", 4'h1);

    // Reset during the second EXEC cycle of a repeat command
    present(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 4'h3, 2'd3);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    peek(2'd1, "midrst_r1", 4'h0);
    peek(2'd3, "midrst_r3", 4'h0);
    check("midrst_done", 8'(done), 8'h0);
    check("midrst_flags", 8'({flag_c, flag_z, flag_v}), 8'h0);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", 8'(cmd_ready), 8'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_no_done", 8'(done), 8'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front end for the 4-bit combinational ALU. It accepts ALU commands over a valid/ready handshake and owns a small register file. It drives the ALU's select, in_c, in_x and in_y inputs, then writes the ALU result and flags back on the following clock edge. An optional repeat count iterates one operation on its destination register, for example repeated add.

## Interface
Parameters:
- NREG, 4, number of 4-bit registers (power of two, ≥2); AW = log2(NREG)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept
- cmd_op  in  3  ALU select encoding (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed-less-than, 111 equal)
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  x-operand register, first iteration only
- cmd_rs2  in  AW  y-operand register
- cmd_imm_en  in  1  y operand = cmd_imm instead of R[rs2]
- cmd_imm  in  4  immediate
- cmd_rep  in  2  extra iterations (0..3)
- alu_select  out  3  to ALU select
- alu_in_c  out  1  to ALU in_c
- alu_in_x  out  4  to ALU in_x
- alu_in_y  out  4  to ALU in_y
- alu_out_s  in  4  from ALU
- alu_out_c  in  1  from ALU
- alu_zero  in  1  from ALU
- alu_overflow  in  1  from ALU
- done  out  1  one-cycle pulse after final writeback
- flag_c, flag_z, flag_v  out  1 each  flags from last writeback
- dbg_addr  in  AW  debug read address
- dbg_data  out  4  R[dbg_addr], combinational

## Operation
- State IDLE:
  - cmd_ready = 1.
  - Accept on cmd_valid & cmd_ready.
  - Latch op, rd, rs1, rs2, imm_en, imm into command registers.
  - Load iteration counter = cmd_rep; set first = 1; go to EXEC.
- State EXEC:
  - cmd_ready = 0; cmd_valid is ignored.
  - alu_select = latched op.
  - alu_in_c = 1 for ops 001, 110 and 111 (the ALU needs in_c = 1 to invert y); otherwise 0.
  - alu_in_x = first ? R[rs1] : R[rd].
  - alu_in_y = imm_en ? imm : R[rs2], re-read each iteration, so if rs2 == rd the updated value is used.
  - At the clock edge: R[rd] ← alu_out_s; flag_c/z/v ← alu_out_c/alu_zero/alu_overflow; first ← 0.
  - If counter == 0: go to IDLE and assert done for the next cycle. Otherwise decrement the counter and stay in EXEC.
- ALU drive in IDLE: alu_select = 000, alu_in_c = 0, alu_in_x = 0, alu_in_y = 0.
- Arithmetic is 4-bit modulo, with no width extension. Ops 110 and 111 write 000b where b is the ALU compare bit.
- dbg_data reflects a writeback from the cycle after the writing edge.

## Timing
- Reset (rst_n low at a rising edge):
  - All R[i] = 0 and flag_c/z/v = 0.
  - done = 0; state = IDLE; counter = 0.
  - cmd_ready = 0 while rst_n is low, 1 from the first cycle after release.
- Command accepted at edge T:
  - EXEC occupies cycles T+1 .. T+1+rep.
  - Final writeback happens at the end of cycle T+1+rep.
  - done = 1 and cmd_ready = 1 in cycle T+2+rep.
- Throughput: one command per (rep + 2) cycles. No back-to-back acceptance in the same cycle as the final writeback.
- Reset mid-EXEC: abort with no writeback on that edge. Everything is cleared and done is not pulsed.
- Simultaneous done and a new cmd_valid: the command is accepted in that cycle (IDLE).
- rd == rs1 with rep = 0 is legal: a read followed by an overwrite.

## Test plan
- Reset: rst_n low 2 cycles, then release -> dbg_data = 0 for every address, flags 0, done 0, cmd_ready 1 from the first released cycle.
- Immediate add: op 000, rd = 1, rs1 = 0, imm_en = 1, imm = 5, rep = 0, accepted at T -> alu_in_c = 0 and alu_in_x = 0 in T+1; R1 = 5, done = 1 in T+2; flag_z = 0.
- Subtract: R1 = 5, R2 = 7; op 001, rd = 3, rs1 = 1, rs2 = 2 -> alu_in_c = 1, x = 5, y = 7 in EXEC; R3 = 4'hE; flag_v = 0.
- Repeat: R1 = 3; op 000, rd = 1, rs1 = 1, imm = 3, rep = 3; cmd_valid held high -> 4 EXEC cycles with x = 3, 6, 9, 12; R1 = 15; done at T+5; cmd_ready low T+1..T+4.
- Compare: R1 = 4'hF, R2 = 1; op 110, rd = 3 -> R3 = 4'h1. Then op 111 with rs1 = rs2 = 2 -> R3 = 4'h1.
- Reset mid-op: repeat command with rep = 3, rst_n low in the second EXEC cycle -> R1 = 0, done never asserts, cmd_ready 1 after release.
